// File: rtl/sonar_scan_scheduler_if.sv
// rtl/sonar_scan_scheduler_if.sv - sensor pins and measurement bus of the sonar scan scheduler
interface sonar_scan_scheduler_if #(
  parameter int N_SENS = 3,
  parameter int CNT_W  = 24
);
  logic              enable;
  logic [N_SENS-1:0] echo;
  logic [N_SENS-1:0] trigger;
  logic [2:0]        active_idx;
  logic              dist_valid;
  logic [2:0]        dist_idx;
  logic [CNT_W-1:0]  dist_count;
  logic              timeout;
  logic [N_SENS-1:0] near;

  modport master (
    input  enable, echo,
    output trigger, active_idx, dist_valid, dist_idx, dist_count, timeout, near
  );

  modport slave (
    output enable, echo,
    input  trigger, active_idx, dist_valid, dist_idx, dist_count, timeout, near
  );
endinterface

// File: rtl/sonar_scan_scheduler.sv
// rtl/sonar_scan_scheduler.sv - slot-multiplexed ultrasonic ranging scheduler with per-sensor near flags
// Optional near hysteresis (release above FAR_THR) is enabled by defining SONAR_NEAR_HYST_EN.
module sonar_scan_scheduler #(
  parameter int N_SENS      = 3,
  parameter int CNT_W       = 24,
  parameter int TRIG_CYC    = 500,
  parameter int SLOT_CYC    = 3000000,
  parameter int RISE_TO_CYC = 50000,
  parameter int MAX_ECHO    = 1450000,
  parameter int NEAR_THR    = 1044,
  parameter int FAR_THR     = 1500
) (
  input  logic                  clk,
  input  logic                  rst_n,
  sonar_scan_scheduler_if.master bus
);

  localparam logic [CNT_W-1:0]  TRIG_LAST = CNT_W'(TRIG_CYC - 1);
  localparam logic [CNT_W-1:0]  SLOT_LAST = CNT_W'(SLOT_CYC - 1);
  localparam logic [CNT_W-1:0]  RISE_LAST = CNT_W'(RISE_TO_CYC - 1);
  localparam logic [CNT_W-1:0]  MAX_CNT   = CNT_W'(MAX_ECHO);
  localparam logic [CNT_W-1:0]  NEAR_LVL  = CNT_W'(NEAR_THR);
`ifdef SONAR_NEAR_HYST_EN
  localparam logic [CNT_W-1:0]  FAR_LVL   = CNT_W'(FAR_THR);
`endif
  localparam logic [N_SENS-1:0] ONE_HOT0  = N_SENS'(1);
  localparam logic [2:0]        LAST_IDX  = 3'(N_SENS - 1);

  typedef enum logic [2:0] {IDLE, TRIG, WAIT_RISE, MEAS, HOLD} state_t;

  state_t            state;
  logic [N_SENS-1:0] echo_m;
  logic [N_SENS-1:0] echo_s;
  logic              echo_prev;
  logic [CNT_W-1:0]  slot_cnt;
  logic [CNT_W-1:0]  phase_cnt;
  logic [7:0]        echo_pad;
  logic              echo_sel;
  logic              echo_rise;
  logic [2:0]        next_idx;

  always_comb begin
    echo_pad  = 8'(echo_s);
    echo_sel  = echo_pad[bus.active_idx];
    echo_rise = echo_sel & ~echo_prev;
    next_idx  = (bus.active_idx == LAST_IDX) ? 3'd0 : bus.active_idx + 3'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      echo_m         <= '0;
      echo_s         <= '0;
      echo_prev      <= 1'b0;
      slot_cnt       <= '0;
      phase_cnt      <= '0;
      bus.trigger    <= '0;
      bus.active_idx <= '0;
      bus.dist_valid <= 1'b0;
      bus.dist_idx   <= '0;
      bus.dist_count <= '0;
      bus.timeout    <= 1'b0;
      bus.near       <= '0;
    end else begin
      echo_m         <= bus.echo;
      echo_s         <= echo_m;
      echo_prev      <= echo_sel;
      bus.dist_valid <= 1'b0;
      bus.timeout    <= 1'b0;

      if (state != IDLE) begin
        slot_cnt <= slot_cnt + CNT_W'(1);
      end

      // Near flags follow the measurement one cycle after it is published.
      if (bus.dist_valid) begin
        for (int i = 0; i < N_SENS; i++) begin
          if (bus.dist_idx == 3'(i)) begin
`ifdef SONAR_NEAR_HYST_EN
            if (bus.timeout || (bus.dist_count > FAR_LVL)) begin
              bus.near[i] <= 1'b0;
            end else if (bus.dist_count < NEAR_LVL) begin
              bus.near[i] <= 1'b1;
            end
`else
            bus.near[i] <= ~bus.timeout & (bus.dist_count < NEAR_LVL);
`endif
          end
        end
      end

      case (state)
        IDLE: begin
          if (bus.enable) begin
            state       <= TRIG;
            slot_cnt    <= '0;
            bus.trigger <= ONE_HOT0 << bus.active_idx;
          end
        end
        TRIG: begin
          if (slot_cnt == TRIG_LAST) begin
            bus.trigger <= '0;
            phase_cnt   <= '0;
            state       <= WAIT_RISE;
          end
        end
        WAIT_RISE: begin
          if (echo_rise) begin
            // The rise cycle itself is the first high cycle of the echo.
            phase_cnt <= CNT_W'(1);
            state     <= MEAS;
          end else if (phase_cnt == RISE_LAST) begin
            bus.dist_valid <= 1'b1;
            bus.timeout    <= 1'b1;
            bus.dist_idx   <= bus.active_idx;
            bus.dist_count <= MAX_CNT;
            state          <= HOLD;
          end else begin
            phase_cnt <= phase_cnt + CNT_W'(1);
          end
        end
        MEAS: begin
          if (!echo_sel || (phase_cnt == MAX_CNT)) begin
            bus.dist_valid <= 1'b1;
            bus.dist_idx   <= bus.active_idx;
            bus.dist_count <= phase_cnt;
            state          <= HOLD;
          end else begin
            phase_cnt <= phase_cnt + CNT_W'(1);
          end
        end
        HOLD: begin
          if (slot_cnt == SLOT_LAST) begin
            bus.active_idx <= next_idx;
            if (bus.enable) begin
              state       <= TRIG;
              slot_cnt    <= '0;
              bus.trigger <= ONE_HOT0 << next_idx;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
